// File: rtl/gouram_trace_drain.sv
// gouram_trace_drain
//   Buffers completed 128-bit Gouram trace records in a small FIFO and
//   serialises each one onto a 32-bit valid/ready sink, least significant
//   word first. Records that arrive while the FIFO is full are dropped and
//   counted in a saturating counter.
//
//   Optional feature: define GOURAM_TRACE_TIMESTAMP_EN to tag each record
//   with a free-running 32-bit cycle count taken at the push edge. The
//   timestamp goes out as an extra leading beat, so each record is 5 beats.
//
// Ports
//   clk            clock, all logic on rising edge
//   rst            synchronous active-high reset
//   enable_i       capture enable; buffered records drain regardless
//   trace_valid_i  one-cycle strobe, trace_data_i holds a record
//   trace_data_i   128-bit trace record
//   m_valid_o      beat valid
//   m_data_o       beat payload
//   m_last_o       final beat of a record
//   m_ready_i      sink accepts beat
//   fifo_level_o   records buffered, including the one being sent
//   drop_count_o   records dropped on full, saturating
module gouram_trace_drain #(
  parameter int DEPTH          = 4,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable_i,
  input  logic                      trace_valid_i,
  input  logic [127:0]              trace_data_i,
  output logic                      m_valid_o,
  output logic [31:0]               m_data_o,
  output logic                      m_last_o,
  input  logic                      m_ready_i,
  output logic [$clog2(DEPTH):0]    fifo_level_o,
  output logic [DROP_CNT_WIDTH-1:0] drop_count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
`ifdef GOURAM_TRACE_TIMESTAMP_EN
  localparam int NBEATS = 5;
`else
  localparam int NBEATS = 4;
`endif
  localparam int BW = $clog2(NBEATS);

  // An entry is stored already split into beat-sized words, beat 0 lowest.
  typedef logic [NBEATS-1:0][31:0] entry_t;
  typedef enum logic {IDLE, SEND} state_t;

  entry_t                    mem [DEPTH];
  entry_t                    wr_entry;
  entry_t                    head;
  logic [PW-1:0]             wr_ptr;
  logic [PW-1:0]             rd_ptr;
  logic [LW-1:0]             level;
  logic [BW-1:0]             beat_cnt;
  logic [BW-1:0]             beat_cnt_d;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt;
  state_t                    state_q;
  state_t                    state_d;
  logic                      last_beat;
  logic                      pop;
  logic                      push;
  logic                      drop;

  function automatic logic [DROP_CNT_WIDTH-1:0] sat_inc(
    input logic [DROP_CNT_WIDTH-1:0] x
  );
    return (&x) ? x : x + 1'b1;
  endfunction

`ifdef GOURAM_TRACE_TIMESTAMP_EN
  logic [31:0] ts_cnt;

  always_ff @(posedge clk) begin
    if (rst) ts_cnt <= '0;
    else     ts_cnt <= ts_cnt + 1'b1;
  end

  // Timestamp occupies word 0 so it leaves as the first beat.
  assign wr_entry = {trace_data_i, ts_cnt};
`else
  assign wr_entry = trace_data_i;
`endif

  assign last_beat = (beat_cnt == BW'(NBEATS - 1));
  assign pop       = (state_q == SEND) && m_ready_i && last_beat;
  // A pop on the same edge frees a slot, so a full FIFO still accepts.
  assign push      = trace_valid_i && enable_i && ((level != LW'(DEPTH)) || pop);
  assign drop      = trace_valid_i && enable_i && !push;

  // Record storage: data only, never reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  // Control state: pointers, level, drop counter, FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      drop_cnt <= '0;
      state_q  <= IDLE;
      beat_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (drop) drop_cnt <= sat_inc(drop_cnt);
      state_q  <= state_d;
      beat_cnt <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt;
    case (state_q)
      IDLE: begin
        beat_cnt_d = '0;
        if (push) state_d = SEND;
      end
      SEND: begin
        if (m_ready_i) begin
          if (last_beat) begin
            beat_cnt_d = '0;
            // Only go idle when the popped record was the last one and
            // nothing new lands on the same edge.
            if ((level == LW'(1)) && !push) state_d = IDLE;
          end else begin
            beat_cnt_d = beat_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        beat_cnt_d = '0;
      end
    endcase
  end

  assign head         = mem[rd_ptr];
  assign m_valid_o    = (state_q == SEND);
  assign m_data_o     = m_valid_o ? head[beat_cnt] : '0;
  assign m_last_o     = m_valid_o && last_beat;
  assign fifo_level_o = level;
  assign drop_count_o = drop_cnt;

endmodule
